// File: rtl/sccb_init_seq_if.sv
// sccb_init_seq_if: sequencer <-> sccb_fsm control, tx, busy and rx streams.
// master = sequencer side, slave = sccb_fsm side.
interface sccb_init_seq_if #(
   parameter int DATA_W = 8
);
   logic              trans_type;
   logic [1:0]        phase_amt;
   logic              ctrl_vld;
   logic              ctrl_rdy;
   logic [DATA_W-1:0] tx_sub_adr;
   logic              tx_sub_adr_vld;
   logic              tx_sub_adr_rdy;
   logic [DATA_W-1:0] tx_data;
   logic              tx_data_vld;
   logic              tx_data_rdy;
   logic              fsm_busy;
   logic [DATA_W-1:0] rx_data;
   logic              rx_vld;
   logic              rx_rdy;

   modport master (
      output trans_type, phase_amt, ctrl_vld,
      output tx_sub_adr, tx_sub_adr_vld,
      output tx_data, tx_data_vld, rx_rdy,
      input  ctrl_rdy, tx_sub_adr_rdy, tx_data_rdy,
      input  fsm_busy, rx_data, rx_vld
   );

   modport slave (
      input  trans_type, phase_amt, ctrl_vld,
      input  tx_sub_adr, tx_sub_adr_vld,
      input  tx_data, tx_data_vld, rx_rdy,
      output ctrl_rdy, tx_sub_adr_rdy, tx_data_rdy,
      output fsm_busy, rx_data, rx_vld
   );
endinterface

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a {sub_adr,data} init table, one SCCB write per entry.
// Build option SEQ_VERIFY_EN: read every register back and compare.
module sccb_init_seq #(
   parameter int DATA_W   = 8,
   parameter int TBL_AW   = 8,
   parameter int DLY_UNIT = 1000,
   parameter int TOUT_CYC = 65535
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [TBL_AW-1:0]   err_idx_o,
   output logic [TBL_AW-1:0]   tbl_addr_o,
   input  logic [2*DATA_W-1:0] tbl_data_i,
   sccb_init_seq_if.master     fsm
);
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DELAY,
      S_WAIT_H, S_WAIT_L, S_NEXT, S_DONE, S_ERR
   } state_t;

   localparam logic [DATA_W-1:0] ONES  = '1;
   localparam logic [DATA_W-1:0] DMARK = {{(DATA_W-1){1'b1}}, 1'b0};
   localparam logic [31:0] TOUT_M1 = 32'(TOUT_CYC - 1);
   localparam logic [31:0] DLY_U   = 32'(DLY_UNIT);

   state_t            state;
   logic [TBL_AW-1:0] idx;
   logic [31:0]       dcnt;
   logic [31:0]       tcnt;
   logic [DATA_W-1:0] sub;
   logic [DATA_W-1:0] dat;
   logic [31:0]       dly_len;
   logic              is_end;
   logic              is_dly;
   logic              is_wr;
   logic              tout;

   assign sub     = tbl_data_i[2*DATA_W-1:DATA_W];
   assign dat     = tbl_data_i[DATA_W-1:0];
   assign is_end  = (sub == ONES) && (dat == ONES);
   assign is_dly  = (sub == DMARK);
   assign is_wr   = !is_end && !is_dly;
   assign dly_len = 32'(dat) * DLY_U;
   assign tout    = (tcnt >= TOUT_M1);

`ifdef SEQ_VERIFY_EN
   typedef enum logic [1:0] {ST_WR, ST_VWR, ST_RD} step_t;

   step_t             step;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rx_val;
   logic              rx_got;
   logic              rd_wait;
   logic              rx_acc;
   logic              rx_ok;
   logic              unused_ok;

   assign rd_wait = (state == S_WAIT_H || state == S_WAIT_L)
                 && (step == ST_RD);
   assign rx_acc  = rd_wait && fsm.rx_vld;
   assign rx_ok   = rx_acc ? (fsm.rx_data == wdata)
                           : (rx_got && rx_val == wdata);
   assign fsm.rx_rdy = rd_wait;
   assign unused_ok  = ^{fsm.tx_sub_adr_rdy, fsm.tx_data_rdy};
`else
   logic unused_ok;

   assign fsm.rx_rdy = 1'b1;
   assign unused_ok  = ^{fsm.tx_sub_adr_rdy, fsm.tx_data_rdy,
                         fsm.rx_data, fsm.rx_vld};
`endif

   // table walk, fsm stream drive, delay/timeout counters and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_IDLE;
         idx                <= '0;
         dcnt               <= '0;
         tcnt               <= '0;
         busy_o             <= 1'b0;
         done_o             <= 1'b0;
         err_o              <= 1'b0;
         err_idx_o          <= '0;
         tbl_addr_o         <= '0;
         fsm.trans_type     <= 1'b0;
         fsm.phase_amt      <= 2'd0;
         fsm.ctrl_vld       <= 1'b0;
         fsm.tx_sub_adr     <= '0;
         fsm.tx_sub_adr_vld <= 1'b0;
         fsm.tx_data        <= '0;
         fsm.tx_data_vld    <= 1'b0;
`ifdef SEQ_VERIFY_EN
         step               <= ST_WR;
         wdata              <= '0;
         rx_got             <= 1'b0;
         rx_val             <= '0;
`endif
      end else begin
`ifdef SEQ_VERIFY_EN
         if (rx_acc) begin
            rx_got <= 1'b1;
            rx_val <= fsm.rx_data;
         end
`endif
         unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_i) begin
                  state      <= S_FETCH;
                  idx        <= '0;
                  tbl_addr_o <= '0;
                  busy_o     <= 1'b1;
                  done_o     <= 1'b0;
                  err_o      <= 1'b0;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               unique case (1'b1)
                  is_end: begin
                     state  <= S_DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end
                  // fetch/decode overhead is folded into the delay
                  is_dly: begin
                     if (dly_len <= 32'd3) begin
                        state <= S_NEXT;
                     end else begin
                        dcnt  <= dly_len - 32'd3;
                        state <= S_DELAY;
                     end
                  end
                  is_wr: begin
                     state              <= S_ISSUE;
                     fsm.trans_type     <= 1'b1;
                     fsm.phase_amt      <= 2'd3;
                     fsm.tx_sub_adr     <= sub;
                     fsm.tx_data        <= dat;
                     fsm.ctrl_vld       <= 1'b1;
                     fsm.tx_sub_adr_vld <= 1'b1;
                     fsm.tx_data_vld    <= 1'b1;
`ifdef SEQ_VERIFY_EN
                     step               <= ST_WR;
                     wdata              <= dat;
`endif
                  end
               endcase
            end
            S_DELAY: begin
               if (dcnt <= 32'd1) state <= S_NEXT;
               else dcnt <= dcnt - 32'd1;
            end
            S_ISSUE: begin
               if (fsm.ctrl_rdy) begin
                  fsm.ctrl_vld       <= 1'b0;
                  fsm.tx_sub_adr_vld <= 1'b0;
                  fsm.tx_data_vld    <= 1'b0;
                  tcnt               <= 32'd1;
                  state              <= S_WAIT_H;
               end
            end
            S_WAIT_H, S_WAIT_L: begin
               if (tout) begin
                  state     <= S_ERR;
                  busy_o    <= 1'b0;
                  err_o     <= 1'b1;
                  err_idx_o <= idx;
               end else begin
                  tcnt <= tcnt + 32'd1;
                  if (state == S_WAIT_H && fsm.fsm_busy) begin
                     state <= S_WAIT_L;
                  end else if (state == S_WAIT_L && !fsm.fsm_busy) begin
`ifdef SEQ_VERIFY_EN
                     unique case (step)
                        ST_WR: begin
                           step               <= ST_VWR;
                           state              <= S_ISSUE;
                           fsm.trans_type     <= 1'b1;
                           fsm.phase_amt      <= 2'd2;
                           fsm.ctrl_vld       <= 1'b1;
                           fsm.tx_sub_adr_vld <= 1'b1;
                        end
                        ST_VWR: begin
                           step           <= ST_RD;
                           state          <= S_ISSUE;
                           fsm.trans_type <= 1'b0;
                           fsm.phase_amt  <= 2'd2;
                           fsm.ctrl_vld   <= 1'b1;
                           rx_got         <= 1'b0;
                        end
                        default: begin
                           if (rx_ok) begin
                              state <= S_NEXT;
                           end else begin
                              state     <= S_ERR;
                              busy_o    <= 1'b0;
                              err_o     <= 1'b1;
                              err_idx_o <= idx;
                           end
                        end
                     endcase
`else
                     state <= S_NEXT;
`endif
                  end
               end
            end
            S_NEXT: begin
               if (&idx) begin
                  state  <= S_DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else begin
                  idx        <= idx + 1'b1;
                  tbl_addr_o <= idx + 1'b1;
                  state      <= S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq: init tables against a table-walk reference model.
// A behavioural sccb_fsm stand-in answers the sequencer's streams.
`timescale 1ns/1ps
module tb_sccb_init_seq;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DU = 10;
   localparam int TO = 100;
   localparam int NE = 1 << AW;
`ifdef SEQ_VERIFY_EN
   localparam int TPE = 3;
   localparam logic RXR0 = 1'b0;
`else
   localparam int TPE = 1;
   localparam logic RXR0 = 1'b1;
`endif

   typedef struct packed {
      logic       tt;
      logic [1:0] ph;
      logic [7:0] sub;
      logic [7:0] dat;
      logic       sv;
      logic       dv;
   } hs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, err;
   logic [AW-1:0] err_idx, tbl_addr;
   logic [2*DW-1:0] tbl_data;
   logic [15:0] rom [NE];

   int total = 0;
   int bad = 0;

   logic hold = 1'b0;
   logic stuck_en = 1'b0;
   int stuck_at = 0;
   int busy_len = 8;
   logic corrupt = 1'b0;

   int bcnt = 0;
   logic rd_pend = 1'b0;
   int hs_count = 0;
   hs_t hlog [$];
   logic [7:0] regs [256];
   logic [7:0] cur_sub = 8'h00;
   logic [15:0] exp_w [$];

   sccb_init_seq_if #(.DATA_W(DW)) f ();

   sccb_init_seq #(
      .DATA_W(DW), .TBL_AW(AW), .DLY_UNIT(DU), .TOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start),
      .busy_o(busy), .done_o(done), .err_o(err),
      .err_idx_o(err_idx), .tbl_addr_o(tbl_addr),
      .tbl_data_i(tbl_data), .fsm(f)
   );

   always #5 clk = ~clk;

   // synchronous table ROM
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   assign f.ctrl_rdy       = !hold;
   assign f.tx_sub_adr_rdy = !hold;
   assign f.tx_data_rdy    = !hold;
   assign f.fsm_busy = (bcnt != 0) || (stuck_en && hs_count > stuck_at);
   assign f.rx_vld   = rd_pend && (bcnt == 1);
   assign f.rx_data  = regs[cur_sub] ^ {8{corrupt}};

   // fsm stand-in: logs handshakes, stays busy, returns register reads
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt    <= 0;
         rd_pend <= 1'b0;
      end else if (f.ctrl_vld && f.ctrl_rdy) begin
         hlog.push_back('{f.trans_type, f.phase_amt, f.tx_sub_adr,
                          f.tx_data, f.tx_sub_adr_vld, f.tx_data_vld});
         hs_count <= hs_count + 1;
         bcnt     <= busy_len;
         rd_pend  <= !f.trans_type;
         if (f.trans_type && f.phase_amt == 2'd3)
            regs[f.tx_sub_adr] <= f.tx_data;
         if (f.trans_type && f.phase_amt == 2'd2)
            cur_sub <= f.tx_sub_adr;
      end else begin
         if (bcnt != 0) bcnt <= bcnt - 1;
         if (f.rx_vld && f.rx_rdy) rd_pend <= 1'b0;
      end
   end

   // reference: writes the table should produce, in order
   task automatic walk_table();
      exp_w.delete();
      for (int i = 0; i < NE; i++) begin
         if (rom[i] == 16'hFFFF) break;
         if (rom[i][15:8] != 8'hFE) exp_w.push_back(rom[i]);
      end
   endtask

   // -1 when logged handshakes since base equal the expected stream
   function automatic int log_diff(input int base);
      int n;
      hs_t h;
      hs_t e;
      logic [15:0] w;
      n = hlog.size() - base;
      if (n != exp_w.size() * TPE) return 1000 + n;
      for (int k = 0; k < n; k++) begin
         h = hlog[base + k];
         w = exp_w[k / TPE];
         if (k % TPE == 0)
            e = '{1'b1, 2'd3, w[15:8], w[7:0], 1'b1, 1'b1};
         else if (k % TPE == 1)
            e = '{1'b1, 2'd2, w[15:8], h.dat, 1'b1, 1'b0};
         else
            e = '{1'b0, 2'd2, h.sub, h.dat, 1'b0, 1'b0};
         if (h !== e) return k;
      end
      return -1;
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < NE; i++) rom[i] = 16'hFFFF;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_end(input string nm, input int lim);
      int c;
      c = 0;
      while (!(done || err) && c < lim) begin
         @(posedge clk);
         #1 c++;
      end
      total++;
      if (!(done || err)) begin
         bad++;
         $display("FAIL %s_end: no done/err after %0d cycles", nm, lim);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, done, err} !== 3'b000) begin
         bad++;
         $display("FAIL reset_status: got %b want 000", {busy, done, err});
      end
      total++;
      if ({f.ctrl_vld, f.tx_sub_adr_vld, f.tx_data_vld,
           f.trans_type, f.phase_amt} !== 6'b0) begin
         bad++;
         $display("FAIL reset_stream: vld/type/phase not all 0");
      end
      total++;
      if (tbl_addr !== '0 || err_idx !== '0) begin
         bad++;
         $display("FAIL reset_addr: addr=%0d idx=%0d want 0",
                  tbl_addr, err_idx);
      end
      total++;
      if (f.rx_rdy !== RXR0) begin
         bad++;
         $display("FAIL reset_rx_rdy: got %b want %b", f.rx_rdy, RXR0);
      end
   endtask

   task automatic test_basic();
      int base;
      int d;
      clear_rom();
      rom[0] = 16'h1280;
      rom[1] = 16'h1101;
      busy_len = 40;
      base = hlog.size();
      pulse_start();
      wait_end("basic", 5000);
      walk_table();
      d = log_diff(base);
      total++;
      if (d !== -1) begin
         bad++;
         $display("FAIL basic_log: diff at %0d want -1 (n=%0d)",
                  d, hlog.size() - base);
      end
      total++;
      if ({done, err, busy} !== 3'b100) begin
         bad++;
         $display("FAIL basic_status: got %b want 100", {done, err, busy});
      end
   endtask

   task automatic test_delay();
      int base;
      int c;
      clear_rom();
      rom[0] = 16'hFE03;
      busy_len = 8;
      base = hlog.size();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      c = 0;
      while (!done && c < 200) begin
         @(posedge clk);
         #1 c++;
      end
      total++;
      if (c - 1 < 28 || c - 1 > 32) begin
         bad++;
         $display("FAIL delay_time: %0d cycles after decode want 30+/-2",
                  c - 1);
      end
      total++;
      if (hlog.size() - base !== 0) begin
         bad++;
         $display("FAIL delay_no_ctrl: %0d handshakes want 0",
                  hlog.size() - base);
      end
   endtask

   task automatic test_stall();
      int base;
      int c;
      int unstable;
      logic [18:0] p;
      clear_rom();
      rom[0] = 16'h1280;
      busy_len = 6;
      hold = 1'b1;
      base = hlog.size();
      pulse_start();
      c = 0;
      while (!f.ctrl_vld && c < 20) begin
         @(posedge clk);
         #1 c++;
      end
      p = {f.trans_type, f.phase_amt, f.tx_sub_adr, f.tx_data};
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (!(f.ctrl_vld && f.tx_sub_adr_vld && f.tx_data_vld) ||
             {f.trans_type, f.phase_amt, f.tx_sub_adr, f.tx_data} !== p)
            unstable++;
      end
      total++;
      if (unstable !== 0 || p !== {1'b1, 2'd3, 16'h1280}) begin
         bad++;
         $display("FAIL stall_stable: %0d bad cycles, payload %h want 0/%h",
                  unstable, p, {1'b1, 2'd3, 16'h1280});
      end
      total++;
      if (hlog.size() - base !== 0) begin
         bad++;
         $display("FAIL stall_no_hs: %0d handshakes want 0",
                  hlog.size() - base);
      end
      hold = 1'b0;
      wait_end("stall", 2000);
      walk_table();
      total++;
      if (log_diff(base) !== -1 || !done) begin
         bad++;
         $display("FAIL stall_single: n=%0d done=%b want %0d/1",
                  hlog.size() - base, done, TPE);
      end
   endtask

   task automatic test_timeout(input int ent);
      int base;
      int k;
      int c;
      clear_rom();
      rom[0] = 16'h1280;
      rom[1] = 16'h3456;
      busy_len = 5;
      stuck_at = hlog.size() + ent * TPE;
      stuck_en = 1'b1;
      pulse_start();
      k = 100000;
      c = 0;
      while (c < 2000) begin
         @(posedge clk);
         #1 c++;
         k++;
         if (err) break;
         if (f.ctrl_vld && f.ctrl_rdy) k = 0;
      end
      total++;
      if ({err, done, busy, f.ctrl_vld} !== 4'b1000) begin
         bad++;
         $display("FAIL tout_status: err/done/busy/vld=%b want 1000",
                  {err, done, busy, f.ctrl_vld});
      end
      total++;
      if (err_idx !== ent[AW-1:0]) begin
         bad++;
         $display("FAIL tout_idx: got %0d want %0d", err_idx, ent);
      end
      if (ent == 0) begin
         total++;
         if (k < TO - 1 || k > TO + 1) begin
            bad++;
            $display("FAIL tout_time: %0d cycles want %0d", k, TO);
         end
      end
      stuck_en = 1'b0;
      base = hlog.size();
      pulse_start();
      total++;
      if ({err, busy} !== 2'b01 || tbl_addr !== '0) begin
         bad++;
         $display("FAIL tout_restart: err/busy=%b addr=%0d want 01/0",
                  {err, busy}, tbl_addr);
      end
      wait_end("tout", 5000);
      walk_table();
      total++;
      if (log_diff(base) !== -1 || !done) begin
         bad++;
         $display("FAIL tout_rerun: diff=%0d done=%b want -1/1",
                  log_diff(base), done);
      end
   endtask

   task automatic test_ignore_start();
      int base;
      clear_rom();
      for (int i = 0; i < 5; i++) rom[i] = 16'h2000 + 16'(i * 17);
      busy_len = 10;
      base = hlog.size();
      pulse_start();
      repeat (25) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL ign_busy: got %b want 1", busy);
      end
      pulse_start();
      wait_end("ign", 5000);
      walk_table();
      total++;
      if (log_diff(base) !== -1 || !done) begin
         bad++;
         $display("FAIL ign_log: diff=%0d done=%b want -1/1",
                  log_diff(base), done);
      end
   endtask

   task automatic test_reset_mid();
      int c;
      clear_rom();
      rom[0] = 16'h1280;
      hold = 1'b1;
      pulse_start();
      c = 0;
      while (!f.ctrl_vld && c < 20) begin
         @(posedge clk);
         #1 c++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, err, f.ctrl_vld, f.tx_sub_adr_vld,
           f.tx_data_vld, f.trans_type, f.phase_amt} !== 9'b0 ||
          tbl_addr !== '0 || f.rx_rdy !== RXR0) begin
         bad++;
         $display("FAIL rst_mid: outputs not at reset values, vld=%b",
                  f.ctrl_vld);
      end
      hold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random(input int iters);
      int base;
      int d;
      for (int it = 0; it < iters; it++) begin
         clear_rom();
         for (int i = 0; i < NE; i++) begin
            if ($urandom_range(0, 9) < 2)
               rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
            else
               rom[i] = 16'($urandom);
         end
         if ($urandom_range(0, 3) != 0)
            rom[$urandom_range(0, NE - 1)] = 16'hFFFF;
         busy_len = $urandom_range(1, 12);
         base = hlog.size();
         pulse_start();
         wait_end("rand", 40000);
         walk_table();
         d = log_diff(base);
         total++;
         if (d !== -1 || {done, err} !== 2'b10) begin
            bad++;
            $display("FAIL rand_%0d: diff=%0d done/err=%b want -1/10",
                     it, d, {done, err});
         end
      end
   endtask

`ifdef SEQ_VERIFY_EN
   task automatic test_verify();
      clear_rom();
      rom[0] = 16'h1280;
      busy_len = 7;
      corrupt = 1'b1;
      pulse_start();
      wait_end("vfy_bad", 3000);
      total++;
      if ({err, done} !== 2'b10 || err_idx !== '0) begin
         bad++;
         $display("FAIL vfy_bad: err/done=%b idx=%0d want 10/0",
                  {err, done}, err_idx);
      end
      corrupt = 1'b0;
      pulse_start();
      wait_end("vfy_ok", 3000);
      total++;
      if ({err, done} !== 2'b01) begin
         bad++;
         $display("FAIL vfy_ok: err/done=%b want 01", {err, done});
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      clear_rom();
      test_reset();
      test_basic();
      test_delay();
      test_stall();
      test_timeout(0);
      test_timeout(1);
      test_ignore_start();
      test_reset_mid();
      test_random(6);
`ifdef SEQ_VERIFY_EN
      test_verify();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
